// File: rtl/spi_controller_mc_if.sv
// Host handshake plus SPI pin bundle for spi_controller_mc.
// "master" is the host/peripheral side; "slave" is the controller side.
interface spi_controller_mc_if #(
  parameter int DATA_WIDTH = 16,
  parameter int NUM_CS     = 2,
  parameter int CS_W       = 1
);
  logic                  start;
  logic [CS_W-1:0]       cs_sel;
  logic                  cpol;
  logic                  cpha;
  logic [DATA_WIDTH-1:0] tx_data;
  logic [DATA_WIDTH-1:0] rx_data;
  logic                  busy;
  logic                  done;
  logic                  sck;
  logic                  sdo;
  logic                  sdi;
  logic [NUM_CS-1:0]     cs_n;

  modport master (output start, cs_sel, cpol, cpha, tx_data, sdi,
                  input  rx_data, busy, done, sck, sdo, cs_n);
  modport slave  (input  start, cs_sel, cpol, cpha, tx_data, sdi,
                  output rx_data, busy, done, sck, sdo, cs_n);
endinterface

// File: rtl/spi_controller_mc.sv
// Full-duplex MSB-first SPI controller with per-transaction CPOL/CPHA and
// NUM_CS active-low selects; all outputs registered.
module spi_controller_mc #(
  parameter int DATA_WIDTH = 16,
  parameter int NUM_CS     = 2,
  parameter int CLK_DIV    = 2,
  parameter int CS_W       = 1,
  parameter int CNT_WIDTH  = 6
) (
  input  logic                clk,
  input  logic                nrst,
  spi_controller_mc_if.slave  bus
);
  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int MSB   = DATA_WIDTH - 1;

  typedef enum logic [2:0] {S_IDLE, S_SETUP, S_SHIFT, S_HOLD, S_DONE} state_t;

  state_t                r_state, w_next;
  logic [DIV_W-1:0]      r_div;
  logic [CNT_WIDTH-1:0]  r_edge;
  logic [DATA_WIDTH-1:0] r_tx, r_rx, r_rx_data;
  logic [CS_W-1:0]       r_cs_sel;
  logic                  r_cpol, r_cpha;
  logic                  r_sck, r_sdo, r_busy, r_done;
  logic [NUM_CS-1:0]     r_cs_n, w_cs_n_next;
  logic                  w_div_end, w_last_edge, w_odd_edge, w_sample, w_advance;
  logic                  w_busy_next;
  logic [CS_W-1:0]       w_sel;

  assign w_div_end   = (r_div == DIV_W'(CLK_DIV - 1));
  assign w_last_edge = (r_edge == CNT_WIDTH'(2 * DATA_WIDTH - 1));
  // r_edge holds the count of edges already made, so the upcoming edge is odd when it is even
  assign w_odd_edge  = ~r_edge[0];
  assign w_sample    = r_cpha ? ~w_odd_edge : w_odd_edge;
  assign w_advance   = r_cpha ? w_odd_edge : (~w_odd_edge & ~w_last_edge);

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (bus.start) w_next = S_SETUP;
      S_SETUP: if (w_div_end) w_next = S_SHIFT;
      S_SHIFT: if (w_div_end && w_last_edge) w_next = S_HOLD;
      S_HOLD:  if (w_div_end) w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Select decode looks ahead one state so cs_n lines up with busy
  assign w_busy_next = (w_next inside {S_SETUP, S_SHIFT, S_HOLD});
  assign w_sel       = (r_state == S_IDLE) ? bus.cs_sel : r_cs_sel;

  always_comb begin
    w_cs_n_next = '1;
    for (int i = 0; i < NUM_CS; i++)
      if (w_busy_next && (w_sel == CS_W'(i))) w_cs_n_next[i] = 1'b0;
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_div     <= '0;
      r_edge    <= '0;
      r_tx      <= '0;
      r_rx      <= '0;
      r_rx_data <= '0;
      r_cs_sel  <= '0;
      r_cpol    <= 1'b0;
      r_cpha    <= 1'b0;
      r_sck     <= 1'b0;
      r_sdo     <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_cs_n    <= '1;
    end else begin
      r_busy <= w_busy_next;
      r_done <= (w_next == S_DONE);
      r_cs_n <= w_cs_n_next;
      if (w_next == S_DONE) r_rx_data <= r_rx;
      if (r_state inside {S_SETUP, S_SHIFT, S_HOLD})
        r_div <= w_div_end ? '0 : r_div + 1'b1;
      if (r_state == S_IDLE && bus.start) begin
        r_cs_sel <= bus.cs_sel;
        r_cpol   <= bus.cpol;
        r_cpha   <= bus.cpha;
        r_sck    <= bus.cpol;
        r_div    <= '0;
        r_edge   <= '0;
        r_rx     <= '0;
        // cpha=0 drives the MSB during setup; cpha=1 presents it on the first edge
        r_sdo    <= bus.cpha ? 1'b0 : bus.tx_data[MSB];
        r_tx     <= bus.cpha ? bus.tx_data : (bus.tx_data << 1);
      end
      if (r_state == S_SHIFT && w_div_end) begin
        r_sck  <= ~r_sck;
        r_edge <= r_edge + 1'b1;
        if (w_sample)  r_rx <= {r_rx[MSB-1:0], bus.sdi};
        if (w_advance) begin
          r_sdo <= r_tx[MSB];
          r_tx  <= r_tx << 1;
        end
      end
    end
  end

  assign bus.sck     = r_sck;
  assign bus.sdo     = r_sdo;
  assign bus.cs_n    = r_cs_n;
  assign bus.busy    = r_busy;
  assign bus.done    = r_done;
  assign bus.rx_data = r_rx_data;
endmodule

// File: tb/tb_spi_controller_mc.sv
// Three controllers (CLK_DIV=2/NUM_CS=2, CLK_DIV=2/NUM_CS=1, CLK_DIV=1/NUM_CS=2)
// share stimulus; a timing-formula model predicts every output each cycle.
module tb_spi_controller_mc;
  logic       clk = 1'b0;
  logic       nrst = 1'b1;
  logic       start = 1'b0;
  logic       cs_sel = 1'b0;
  logic       cpol = 1'b0;
  logic       cpha = 1'b0;
  logic [7:0] tx = 8'h00;
  logic       slave_en = 1'b0;
  logic       sl_sdi = 1'b0;
  int         sl_idx = 7;
  logic [7:0] sl_word = 8'hC3;
  logic       cap_en = 1'b0;
  logic [7:0] cap = 8'h00;
  int         n_chk = 0;
  int         n_pass = 0;

  always #5 clk = ~clk;

  spi_controller_mc_if #(.DATA_WIDTH(8), .NUM_CS(2), .CS_W(1)) ifa ();
  spi_controller_mc_if #(.DATA_WIDTH(8), .NUM_CS(1), .CS_W(1)) ifb ();
  spi_controller_mc_if #(.DATA_WIDTH(8), .NUM_CS(2), .CS_W(1)) ifc ();

  spi_controller_mc #(.DATA_WIDTH(8), .NUM_CS(2), .CLK_DIV(2), .CS_W(1), .CNT_WIDTH(6))
    u_a (.clk(clk), .nrst(nrst), .bus(ifa));
  spi_controller_mc #(.DATA_WIDTH(8), .NUM_CS(1), .CLK_DIV(2), .CS_W(1), .CNT_WIDTH(6))
    u_b (.clk(clk), .nrst(nrst), .bus(ifb));
  spi_controller_mc #(.DATA_WIDTH(8), .NUM_CS(2), .CLK_DIV(1), .CS_W(1), .CNT_WIDTH(6))
    u_c (.clk(clk), .nrst(nrst), .bus(ifc));

  assign ifa.start = start;  assign ifb.start = start;  assign ifc.start = start;
  assign ifa.cs_sel = cs_sel; assign ifb.cs_sel = cs_sel; assign ifc.cs_sel = cs_sel;
  assign ifa.cpol = cpol;    assign ifb.cpol = cpol;    assign ifc.cpol = cpol;
  assign ifa.cpha = cpha;    assign ifb.cpha = cpha;    assign ifc.cpha = cpha;
  assign ifa.tx_data = tx;   assign ifb.tx_data = tx;   assign ifc.tx_data = tx;
  assign ifa.sdi = slave_en ? sl_sdi : ifa.sdo;
  assign ifb.sdi = ifb.sdo;
  assign ifc.sdi = ifc.sdo;

  // Mode-3 peripheral on instance A: next bit on each falling SCK
  always @(negedge ifa.sck)
    if (slave_en && sl_idx >= 0) begin
      sl_sdi <= sl_word[sl_idx];
      sl_idx <= sl_idx - 1;
    end

  always @(posedge ifa.sck)
    if (cap_en) cap <= {cap[6:0], ifa.sdo};

  function automatic int cdv(input int i);
    return (i == 2) ? 1 : 2;
  endfunction
  function automatic int ncsv(input int i);
    return (i == 1) ? 1 : 2;
  endfunction

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, got, exp);
  endtask

  // Model: m_t = cycles since busy rose (-1 idle); word length 18*CLK_DIV incl. setup/hold
  int         m_t[3]   = '{-1, -1, -1};
  logic [7:0] m_tx[3]  = '{8'h0, 8'h0, 8'h0};
  logic [7:0] m_wd[3]  = '{8'h0, 8'h0, 8'h0};
  logic [7:0] m_rx[3]  = '{8'h0, 8'h0, 8'h0};
  logic       m_cpol[3] = '{1'b0, 1'b0, 1'b0};
  logic       m_cpha[3] = '{1'b0, 1'b0, 1'b0};
  int         m_sel[3] = '{0, 0, 0};

  always @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      for (int i = 0; i < 3; i++) begin
        m_t[i] <= -1; m_cpol[i] <= 1'b0; m_rx[i] <= 8'h00;
      end
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (m_t[i] < 0) begin
          if (start) begin
            m_t[i] <= 0; m_tx[i] <= tx; m_cpol[i] <= cpol; m_cpha[i] <= cpha;
            m_sel[i] <= int'(cs_sel);
            m_wd[i] <= (i == 0 && slave_en) ? sl_word : tx;
          end
        end else if (m_t[i] >= 18 * cdv(i)) m_t[i] <= -1;
        else begin
          m_t[i] <= m_t[i] + 1;
          if (m_t[i] + 1 == 18 * cdv(i)) m_rx[i] <= m_wd[i];
        end
      end
    end
  end

  logic       a_busy[3], a_done[3], a_sck[3], a_sdo[3];
  logic [1:0] a_cs[3];
  logic [7:0] a_rx[3];
  assign a_busy = '{ifa.busy, ifb.busy, ifc.busy};
  assign a_done = '{ifa.done, ifb.done, ifc.done};
  assign a_sck  = '{ifa.sck, ifb.sck, ifc.sck};
  assign a_sdo  = '{ifa.sdo, ifb.sdo, ifc.sdo};
  assign a_cs   = '{ifa.cs_n, {1'b1, ifb.cs_n}, ifc.cs_n};
  assign a_rx   = '{ifa.rx_data, ifb.rx_data, ifc.rx_data};

  always @(negedge clk) begin
    int cd, tot, e, idx;
    logic busy_e, done_e, sck_e, sdo_e;
    logic [1:0] cs_e;
    for (int i = 0; i < 3; i++) begin
      cd = cdv(i); tot = 18 * cd;
      busy_e = (m_t[i] >= 0) && (m_t[i] < tot);
      done_e = (m_t[i] == tot);
      e = (m_t[i] < 2 * cd) ? 0 : (m_t[i] - cd) / cd;
      if (e > 16) e = 16;
      sck_e = m_cpol[i] ^ (e % 2 == 1);
      cs_e = 2'b11;
      if (busy_e && m_sel[i] < ncsv(i)) cs_e[m_sel[i]] = 1'b0;
      chk($sformatf("busy[%0d] t=%0d", i, m_t[i]), a_busy[i], busy_e);
      chk($sformatf("done[%0d] t=%0d", i, m_t[i]), a_done[i], done_e);
      chk($sformatf("sck[%0d] t=%0d", i, m_t[i]), a_sck[i], sck_e);
      chk($sformatf("cs_n[%0d] t=%0d", i, m_t[i]), a_cs[i], cs_e);
      chk($sformatf("rx_data[%0d] t=%0d", i, m_t[i]), a_rx[i], m_rx[i]);
      if (m_t[i] >= 0) begin
        if (!m_cpha[i]) begin
          idx = (e / 2 > 7) ? 7 : e / 2;
          sdo_e = m_tx[i][7 - idx];
        end else if (e == 0) sdo_e = 1'b0;
        else begin
          idx = ((e - 1) / 2 > 7) ? 7 : (e - 1) / 2;
          sdo_e = m_tx[i][7 - idx];
        end
        chk($sformatf("sdo[%0d] t=%0d", i, m_t[i]), a_sdo[i], sdo_e);
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // One transfer observed for 40 cycles after busy rises; mid>0 injects an extra start with tx=FF
  task automatic run(input logic [7:0] t, input logic s, input logic p, input logic h,
                     input int mid, output int la, output int lb, output int lc,
                     output int nda, output logic [1:0] csa, output logic csb);
    tx = t; cs_sel = s; cpol = p; cpha = h; start = 1'b1;
    tick();
    start = 1'b0; csa = ifa.cs_n; csb = ifb.cs_n[0];
    la = -1; lb = -1; lc = -1; nda = 0;
    for (int n = 1; n <= 40; n++) begin
      if (n == mid) begin tx = 8'hFF; start = 1'b1; end
      if (n == mid + 1) start = 1'b0;
      tick();
      if (ifa.done) begin nda++; if (la < 0) la = n; end
      if (ifb.done && lb < 0) lb = n;
      if (ifc.done && lc < 0) lc = n;
    end
  endtask

  initial begin
    int la, lb, lc, nda, d;
    logic [1:0] csa;
    logic csb, b1;
    #1 nrst = 1'b0;
    repeat (3) tick();
    nrst = 1'b1;
    tick();
    chk("reset busy", ifa.busy, 1'b0);
    chk("reset cs_n", ifa.cs_n, 2'b11);

    // Reset in the middle of a shift
    tx = 8'hA5; cs_sel = 1'b0; cpol = 1'b0; cpha = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (12) tick();
    #2 nrst = 1'b0;
    #1;
    chk("midreset sck", ifa.sck, 1'b0);
    chk("midreset cs_n", ifa.cs_n, 2'b11);
    chk("midreset busy", ifa.busy, 1'b0);
    chk("midreset done", ifa.done, 1'b0);
    chk("midreset rx", ifa.rx_data, 8'h00);
    chk("midreset cs_n C", ifc.cs_n, 2'b11);
    @(posedge clk); #1 nrst = 1'b1;
    tick();

    // Mode 0, A5 loopback
    cap_en = 1'b1;
    run(8'hA5, 1'b0, 1'b0, 1'b0, -1, la, lb, lc, nda, csa, csb);
    cap_en = 1'b0;
    chk("mode0 sdo bits", cap, 8'hA5);
    chk("mode0 latency", la, 36);
    chk("mode0 rx", ifa.rx_data, 8'hA5);
    chk("mode0 cs_n", csa, 2'b10);
    chk("mode0 C latency", lc, 18);

    // Mode 3 against C3 peripheral; B sees invalid select
    slave_en = 1'b1;
    run(8'h3C, 1'b1, 1'b1, 1'b1, -1, la, lb, lc, nda, csa, csb);
    chk("mode3 rx", ifa.rx_data, 8'hC3);
    chk("mode3 cs_n", csa, 2'b01);
    chk("mode3 sck idle", ifa.sck, 1'b1);
    chk("mode3 C rx", ifc.rx_data, 8'h3C);
    chk("badsel cs_n", csb, 1'b1);
    chk("badsel latency", lb, 36);
    slave_en = 1'b0;

    // Start while shifting is ignored
    run(8'h12, 1'b0, 1'b0, 1'b0, 10, la, lb, lc, nda, csa, csb);
    chk("ignored start dones", nda, 1);
    chk("ignored start rx", ifa.rx_data, 8'h12);

    // Back-to-back on the CLK_DIV=1 instance, mode 0 then mode 1
    tx = 8'h5A; cs_sel = 1'b0; cpol = 1'b0; cpha = 1'b0; start = 1'b1;
    tick();
    start = 1'b0; d = -1;
    for (int n = 1; n <= 30; n++) begin
      tick();
      if (ifc.done) begin d = n; break; end
    end
    chk("b2b first latency", d, 18);
    chk("b2b first rx", ifc.rx_data, 8'h5A);
    tick();
    b1 = ifc.busy;
    tx = 8'h96; cpha = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    chk("b2b idle gap", b1, 1'b0);
    chk("b2b busy +2", ifc.busy, 1'b1);
    d = -1;
    for (int n = 1; n <= 30; n++) begin
      tick();
      if (ifc.done) begin d = n; break; end
    end
    chk("b2b second latency", d, 18);
    chk("b2b second rx", ifc.rx_data, 8'h96);
    repeat (40) tick();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/spi_controller_mc.md
Name: spi_controller_mc

Overview:
- Next-generation SPI controller for the delay-core datapath: full-duplex, MSB-first transfers of parametrised width.
- Fans out to NUM_CS peripherals (ADC, DAC, SRAM) through per-device active-low selects.
- SPI mode (CPOL/CPHA) is chosen per transaction; SCK rate is a parametrised divide of clk.
- Handshake is start/busy/done, replacing the single cs-pulse trigger of the previous controller.

Parameters:
DATA_WIDTH  16  bits per transfer, shifted MSB first on both sdo and sdi
NUM_CS      2   number of chip-select outputs
CLK_DIV     2   clk cycles per SCK half-period; legal range >= 1
CS_W        1   width of cs_sel; set by instantiator to max(1, clog2(NUM_CS))
CNT_WIDTH   6   width of the half-period edge counter; must satisfy 2^CNT_WIDTH > 2*DATA_WIDTH

Ports:
clk      input   1           system clock; all logic on rising edge
nrst     input   1           asynchronous active-low reset
start    input   1           transaction request; sampled only in IDLE
cs_sel   input   CS_W        target device index; latched with start
cpol     input   1           SCK idle level; latched with start
cpha     input   1           0 = sample on leading edge, 1 = sample on trailing edge; latched with start
tx_data  input   DATA_WIDTH  word to transmit; latched with start
rx_data  output  DATA_WIDTH  received word; updated in the DONE cycle, then held
busy     output  1           high in SETUP, SHIFT and HOLD
done     output  1           one-cycle pulse when a transaction completes
sck      output  1           SPI serial clock
sdo      output  1           serial data out
sdi      input   1           serial data in
cs_n     output  NUM_CS      active-low chip selects

Behaviour:
- Clock and reset: one clock, clk. Reset nrst is asynchronous and active-low.
- Reset values (apply immediately on nrst=0, including mid-transfer):
  - state=IDLE
  - sck=0, sdo=0, cs_n=all 1s
  - rx_data=0, busy=0, done=0
  - all latches and counters cleared
- Registered outputs: sck, sdo, cs_n, busy, done and rx_data are all registered; no combinational path from inputs.
- FSM states: IDLE -> SETUP -> SHIFT -> HOLD -> DONE -> IDLE.
- IDLE:
  - sck=cpol of the last latched mode (0 after reset), cs_n all high, busy=0.
  - start=1 at a clk edge: latch tx_data, cs_sel, cpol and cpha; enter SETUP.
- SETUP (CLK_DIV cycles):
  - busy=1, cs_n[cs_sel]=0, sck=latched cpol.
  - cpha=0: sdo = tx MSB for the whole of SETUP.
  - cpha=1: sdo holds 0 until the first SCK edge.
- SHIFT (2*DATA_WIDTH*CLK_DIV cycles):
  - sck toggles every CLK_DIV cycles, giving 2*DATA_WIDTH edges; the edge counter counts them.
  - cpha=0: sdi sampled into the rx shift register on odd edges (1st, 3rd, ...); sdo advances to the next bit on even edges, except after the final edge.
  - cpha=1: sdo advances on odd edges, with the first odd edge presenting the MSB; sdi sampled on even edges.
  - After the last edge sck is back at cpol.
- HOLD (CLK_DIV cycles): cs_n still asserted, sck=cpol, sdo holds the last bit.
- DONE (1 cycle):
  - cs_n all high, busy=0, done=1.
  - rx_data loaded from the shift register in this same cycle.
  - Next state is IDLE.
- Latency: with busy first high after edge k, done is high after edge k + (2*DATA_WIDTH+2)*CLK_DIV. Minimum start-to-start spacing is (2*DATA_WIDTH+2)*CLK_DIV + 2 cycles.
- start outside IDLE (including in DONE) is ignored; no queuing.
- Changes to tx_data, cs_sel, cpol or cpha while busy have no effect on the current transfer.
- cs_sel >= NUM_CS: no cs_n asserted; the transfer still runs and done still pulses.
- CLK_DIV=1: SCK toggles every clk; same edge ordering applies.
- Back-to-back transfers with different cpol: sck changes to the new idle level in the first SETUP cycle, at least CLK_DIV cycles before the first edge.

Test Plan:
- Reset mid-transfer: drop nrst during SHIFT -> outputs immediately take reset values (sck=0, cs_n=2'b11, busy=0, done=0, rx_data=0); the next start completes normally.
- Basic mode 0 (DATA_WIDTH=8, CLK_DIV=2, cs_sel=0, cpol=0, cpha=0, tx_data=8'hA5, loopback sdo->sdi):
  - sdo bit sequence is 1,0,1,0,0,1,0,1;
  - done pulses 36 cycles after busy rises;
  - rx_data=8'hA5;
  - cs_n=2'b10 throughout busy.
- Mode 3 (cpol=1, cpha=1, cs_sel=1, tx_data=8'h3C, sdi driven from a model returning 8'hC3 with sdo changing on falling SCK edges and sdi sampled on rising):
  - sck idles high;
  - rx_data=8'hC3;
  - cs_n=2'b01 during busy.
- Ignored start: pulse start and change tx_data=8'hFF during SHIFT of a transfer of 8'h12 -> exactly one done pulse; transmitted word is 8'h12.
- Invalid select: cs_sel=1 with NUM_CS=1 -> cs_n stays high; done still pulses after 36 cycles.
- Back-to-back mode switch with CLK_DIV=1, second start issued the cycle after done (mode 0 then mode 1):
  - second busy rises exactly 2 cycles after the first done;
  - second done 18 cycles later;
  - both rx words correct under loopback.
